muldiv_ctrl: RTL and testbench
==============================

# muldiv_ctrl

Multiply/divide unit controller for the five-stage pipeline. It accepts HI/LO-class instructions from the E stage and models the fixed multi-cycle latency of mult/div. It owns the HI and LO registers and raises a stall request toward the hazard logic whenever a D-stage HI/LO instruction would collide with an operation still in flight. The pipeline treats it as a resource beside the ALU: `result_e` feeds the E-stage result path for mfhi/mflo.

## Interface
Parameters:
- MULT_CYCLES, 5, busy cycles for mult/multu (and madd family), ≥1
- DIV_CYCLES, 10, busy cycles for div/divu, ≥1

Ports:
- clk  in  1  clock, rising edge
- rst  in  1  synchronous active-high reset
- op_e  in  4  E-stage operation code (mdu_pkg encoding; MD_NONE = 0)
- src_a  in  32  forwarded rs value in E
- src_b  in  32  forwarded rt value in E
- md_in_d  in  1  D-stage instruction is any HI/LO-class op
- busy  out  1  a mult/div is in flight
- stall_req  out  1  to hazard unit; OR'ed into the global Stall
- result_e  out  32  HI for MD_MFHI, LO for MD_MFLO, else 0
- hi, lo  out  32  architectural HI/LO (test visibility)

## Operation
- Op codes: NONE 0, MULT 1, MULTU 2, DIV 3, DIVU 4, MFHI 5, MFLO 6, MTHI 7, MTLO 8, MADD 9, MADDU 10, MSUB 11, MSUBU 12.
- FSM states:
  - IDLE (cnt = 0): MULT/MULTU/madd-family → compute 64-bit result into pending regs, load cnt ← MULT_CYCLES, go BUSY. DIV/DIVU → load cnt ← DIV_CYCLES, go BUSY. MTHI/MTLO → write hi/lo at the same edge.
  - BUSY (cnt ≠ 0): cnt decrements each edge. The edge where cnt = 1 commits pending to {hi, lo} and returns to IDLE.
- Arithmetic:
  - mult: {hi, lo} = 64-bit signed product; multu: unsigned.
  - div: lo = quotient truncated toward zero, hi = remainder with the dividend's sign; divu: unsigned.
  - Divisor 0: the busy sequence still runs its full length; hi/lo are not written.
- Outputs:
  - busy = (cnt ≠ 0).
  - stall_req = md_in_d & (busy | op_e ∈ {MULT..DIVU, MADD..MSUBU}).
  - result_e is combinational from the current hi/lo.
- Any op_e ≠ NONE while busy is illegal (the hazard unit prevents it). The block ignores it and holds state; a simulation assertion fires.
- rst at any cycle, including mid-operation: cnt = 0, IDLE, hi = lo = 0, pending discarded.

## Timing
- Reset values: busy 0, stall_req 0 (given md_in_d = 0), hi 0, lo 0, result_e 0.
- Start sampled at edge k → busy = 1 for cycles k+1 … k+N, where N is the latency. New hi/lo are visible after edge k+N.
- MTHI/MTLO at edge k → new value on hi/lo and result_e from cycle k+1.
- stall_req asserts in the start cycle itself, so a D-stage mfhi directly behind a mult stalls.
- The hazard logic inserts a bubble into E while stalling, so op_e presents each operation for exactly one cycle.

## Configuration
- Macro MDU_MADD_EN:
  - Defined: MADD/MADDU/MSUB/MSUBU are legal. At commit, {hi, lo} ← {hi, lo} ± product (signed/unsigned per op), using the {hi, lo} sampled at start; latency MULT_CYCLES.
  - Undefined: codes 9–12 are treated as MD_NONE, and the accumulate adder is not built.

## Structure
- Package mdu_pkg holds the op-code localparams, the 4-bit op width, and the default MULT_CYCLES/DIV_CYCLES.
- One sub-module, muldiv_calc: purely combinational. Takes op, src_a, src_b, hi, lo and produces the 64-bit pending result plus a div_by_zero flag.
- muldiv_ctrl holds the FSM, counter, pending regs and HI/LO.

## Test plan
- MULT 0xFFFFFFFF × 0x00000002 → busy high exactly 5 cycles, then hi = 0xFFFFFFFF, lo = 0xFFFFFFFE. MULTU with the same operands → hi = 0x00000001, lo = 0xFFFFFFFE.
- DIVU 7/2 → after 10 cycles lo = 3, hi = 1. DIV 0xFFFFFFF9 (−7) / 2 → lo = 0xFFFFFFFD, hi = 0xFFFFFFFF.
- MULT at edge k with md_in_d = 1 from cycle k → stall_req = 1 in cycles k … k+5, drops in cycle k+6 once busy is 0; mfhi then returns the new hi.
- DIV with src_b = 0 after MTLO 0x12345678 → busy 10 cycles, lo stays 0x12345678.
- rst asserted during cycle 3 of a MULT → next cycle busy = 0, hi = lo = 0; a later MFLO returns 0.
- With MDU_MADD_EN: MTLO 0xFFFFFFFF, MTHI 0, MADDU 1 × 1 → hi = 0x00000001, lo = 0x00000000. Without the macro, the same op leaves hi = 0, lo = 0xFFFFFFFF, and busy never rises.

Source files
------------

// File: rtl/mdu_pkg.sv
// mdu_pkg: op-code encoding, FSM states and default latencies for the HI/LO unit.
// MDU_MADD_EN enables the multiply-accumulate op codes.
package mdu_pkg;
   localparam int MD_W = 4;
   typedef logic [MD_W-1:0] md_op_t;
   localparam md_op_t MD_NONE  = 4'd0;
   localparam md_op_t MD_MULT  = 4'd1;
   localparam md_op_t MD_MULTU = 4'd2;
   localparam md_op_t MD_DIV   = 4'd3;
   localparam md_op_t MD_DIVU  = 4'd4;
   localparam md_op_t MD_MFHI  = 4'd5;
   localparam md_op_t MD_MFLO  = 4'd6;
   localparam md_op_t MD_MTHI  = 4'd7;
   localparam md_op_t MD_MTLO  = 4'd8;
   localparam md_op_t MD_MADD  = 4'd9;
   localparam md_op_t MD_MADDU = 4'd10;
   localparam md_op_t MD_MSUB  = 4'd11;
   localparam md_op_t MD_MSUBU = 4'd12;
`ifdef MDU_MADD_EN
   localparam md_op_t MD_LAST  = MD_MSUBU;
`else
   localparam md_op_t MD_LAST  = MD_MTLO;
`endif
   localparam int MULT_CYCLES_DEF = 5;
   localparam int DIV_CYCLES_DEF  = 10;
   typedef enum logic {S_IDLE, S_BUSY} md_state_t;
endpackage

// File: rtl/muldiv_calc.sv
// muldiv_calc: combinational 64-bit mult/div (and, with MDU_MADD_EN, accumulate) result.
// Divisor zero yields a don't-care result flagged by div_by_zero.
module muldiv_calc
   import mdu_pkg::*;
(
   input  logic [3:0]  op,
   input  logic [31:0] src_a,
   input  logic [31:0] src_b,
   input  logic [31:0] hi,
   input  logic [31:0] lo,
   output logic [63:0] res,
   output logic        div_by_zero
);
   logic [63:0] w_ps, w_pu, w_prod;
   logic [31:0] w_b, w_qu, w_ru;
   logic signed [31:0] w_qs, w_rs;
   logic w_sgn, w_div;
   assign w_sgn = (op == MD_MULT) | (op == MD_DIV) | (op == MD_MADD) | (op == MD_MSUB);
   assign w_div = (op == MD_DIV) | (op == MD_DIVU);
   assign w_ps = {{32{src_a[31]}}, src_a} * {{32{src_b[31]}}, src_b};
   assign w_pu = {32'b0, src_a} * {32'b0, src_b};
   assign w_prod = w_sgn ? w_ps : w_pu;
   assign div_by_zero = w_div & (src_b == 32'd0);
   // substitute 1 so the dividers never see zero; the result is discarded anyway
   assign w_b = (src_b == 32'd0) ? 32'd1 : src_b;
   assign w_qs = $signed(src_a) / $signed(w_b);
   assign w_rs = $signed(src_a) % $signed(w_b);
   assign w_qu = src_a / w_b;
   assign w_ru = src_a % w_b;
`ifdef MDU_MADD_EN
   logic [63:0] w_acc;
   logic w_sub;
   assign w_sub = (op == MD_MSUB) | (op == MD_MSUBU);
   assign w_acc = w_sub ? {hi, lo} - w_prod : {hi, lo} + w_prod;
   always_comb res = w_div ? (w_sgn ? {32'(w_rs), 32'(w_qs)} : {w_ru, w_qu})
                   : (op >= MD_MADD) ? w_acc : w_prod;
`else
   logic w_unused;
   assign w_unused = ^{hi, lo};
   always_comb res = w_div ? (w_sgn ? {32'(w_rs), 32'(w_qs)} : {w_ru, w_qu}) : w_prod;
`endif
endmodule

// File: rtl/muldiv_ctrl.sv
// muldiv_ctrl: HI/LO owner with fixed-latency mult/div sequencing and D-stage stall request.
// MDU_MADD_EN enables MADD/MADDU/MSUB/MSUBU; otherwise those codes act as MD_NONE.
module muldiv_ctrl
   import mdu_pkg::*;
#(
   parameter int MULT_CYCLES = MULT_CYCLES_DEF,
   parameter int DIV_CYCLES  = DIV_CYCLES_DEF
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [3:0]  op_e,
   input  logic [31:0] src_a,
   input  logic [31:0] src_b,
   input  logic        md_in_d,
   output logic        busy,
   output logic        stall_req,
   output logic [31:0] result_e,
   output logic [31:0] hi,
   output logic [31:0] lo
);
   localparam int CW = $clog2((MULT_CYCLES > DIV_CYCLES ? MULT_CYCLES : DIV_CYCLES) + 1);
   md_state_t r_state, w_state_nx;
   logic [CW-1:0] r_cnt, w_cnt_nx;
   logic [63:0] r_pend, w_pend_nx, r_hilo, w_hilo_nx, w_calc;
   logic r_dz, w_dz_nx, w_dz;
   logic [3:0] w_op;
   logic w_is_mul, w_is_div;
   assign w_op = (op_e > MD_LAST) ? MD_NONE : op_e;
   assign w_is_mul = (w_op == MD_MULT) | (w_op == MD_MULTU) | (w_op >= MD_MADD);
   assign w_is_div = (w_op == MD_DIV) | (w_op == MD_DIVU);
   muldiv_calc u_calc (
      .op(w_op), .src_a(src_a), .src_b(src_b), .hi(r_hilo[63:32]), .lo(r_hilo[31:0]),
      .res(w_calc), .div_by_zero(w_dz)
   );
   always_comb begin
      w_state_nx = r_state;
      w_cnt_nx = r_cnt;
      w_hilo_nx = r_hilo;
      w_pend_nx = r_pend;
      w_dz_nx = r_dz;
      if (r_state == S_IDLE) begin
         if (w_is_mul | w_is_div) begin
            w_state_nx = S_BUSY;
            w_cnt_nx = w_is_mul ? CW'(MULT_CYCLES) : CW'(DIV_CYCLES);
            w_pend_nx = w_calc;
            w_dz_nx = w_dz;
         end else if (w_op == MD_MTHI) w_hilo_nx[63:32] = src_a;
         else if (w_op == MD_MTLO) w_hilo_nx[31:0] = src_a;
      end else begin
         // ops arriving while busy are ignored
         w_cnt_nx = r_cnt - 1'b1;
         if (r_cnt == CW'(1)) begin
            w_state_nx = S_IDLE;
            w_hilo_nx = r_dz ? r_hilo : r_pend;
         end
      end
   end
   always_ff @(posedge clk) begin
      if (rst) begin
         r_state <= S_IDLE;
         r_cnt <= '0;
         r_hilo <= '0;
         r_pend <= '0;
         r_dz <= 1'b0;
      end else begin
         r_state <= w_state_nx;
         r_cnt <= w_cnt_nx;
         r_hilo <= w_hilo_nx;
         r_pend <= w_pend_nx;
         r_dz <= w_dz_nx;
      end
   end
   always @(posedge clk) if (!rst && busy) assert (op_e == MD_NONE);
   assign busy = (r_cnt != '0);
   assign stall_req = md_in_d & (busy | w_is_mul | w_is_div);
   assign hi = r_hilo[63:32];
   assign lo = r_hilo[31:0];
   assign result_e = (w_op == MD_MFHI) ? hi : (w_op == MD_MFLO) ? lo : 32'd0;
endmodule

// File: tb/tb_muldiv_ctrl.sv
// tb_muldiv_ctrl: scoreboard bench for muldiv_ctrl; expected {hi,lo} queued at issue, checked at completion.
module tb_muldiv_ctrl;
   import mdu_pkg::*;
   logic clk = 1'b0, rst = 1'b1, md_in_d = 1'b0;
   logic [3:0] op_e = 4'd0;
   logic [31:0] src_a = '0, src_b = '0;
   logic busy, stall_req;
   logic [31:0] result_e, hi, lo;
   int n_cmp = 0, n_bad = 0;
   logic [63:0] q[$];
   logic [31:0] m_hi = '0, m_lo = '0;
   always #5 clk = ~clk;
   muldiv_ctrl #(.MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
      .clk(clk), .rst(rst), .op_e(op_e), .src_a(src_a), .src_b(src_b), .md_in_d(md_in_d),
      .busy(busy), .stall_req(stall_req), .result_e(result_e), .hi(hi), .lo(lo)
   );
   function automatic logic [63:0] model(input logic [3:0] op, input logic [31:0] a, b, input logic [63:0] cur);
      longint sa, sb;
      logic [63:0] ps, pu, ua, ub;
      int ia, ib;
      sa = longint'($signed(a));
      sb = longint'($signed(b));
      ps = 64'(sa * sb);
      ua = {32'b0, a};
      ub = {32'b0, b};
      pu = ua * ub;
      ia = a;
      ib = b;
      case (op)
         MD_MULT:  return ps;
         MD_MULTU: return pu;
         MD_DIV:   return (b == 0) ? cur : {32'(ia % ib), 32'(ia / ib)};
         MD_DIVU:  return (b == 0) ? cur : {a % b, a / b};
         MD_MTHI:  return {a, cur[31:0]};
         MD_MTLO:  return {cur[63:32], a};
`ifdef MDU_MADD_EN
         MD_MADD:  return cur + ps;
         MD_MADDU: return cur + pu;
         MD_MSUB:  return cur - ps;
         MD_MSUBU: return cur - pu;
`endif
         default:  return cur;
      endcase
   endfunction
   function automatic int lat(input logic [3:0] op);
      if (op >= MD_MULT && op <= MD_MULTU) return 5;
      if (op >= MD_DIV && op <= MD_DIVU) return 10;
`ifdef MDU_MADD_EN
      if (op >= MD_MADD && op <= MD_MSUBU) return 5;
`endif
      return 0;
   endfunction
   task automatic issue(input logic [3:0] op, input logic [31:0] a, b);
      logic [63:0] e;
      e = model(op, a, b, {m_hi, m_lo});
      {m_hi, m_lo} = e;
      q.push_back(e);
      op_e = op;
      src_a = a;
      src_b = b;
      @(negedge clk);
      op_e = MD_NONE;
   endtask
   task automatic drain(output int n);
      n = 0;
      while (busy && n < 40) begin
         n++;
         @(negedge clk);
      end
   endtask
   task automatic test_reset;
      rst = 1'b1;
      repeat (2) @(negedge clk);
      n_cmp++;
      if ({busy, stall_req} !== 2'b00) begin n_bad++; $display("FAIL reset_flags got %b want 00", {busy, stall_req}); end
      n_cmp++;
      if ({hi, lo, result_e} !== 96'd0) begin n_bad++; $display("FAIL reset_hilo got %h want 0", {hi, lo, result_e}); end
      rst = 1'b0;
      m_hi = '0;
      m_lo = '0;
   endtask
   task automatic test_mult;
      int n;
      logic [63:0] e;
      issue(MD_MULT, 32'hFFFFFFFF, 32'h2);
      drain(n);
      e = q.pop_front();
      n_cmp++;
      if (n !== 5) begin n_bad++; $display("FAIL mult_lat got %0d want 5", n); end
      n_cmp++;
      if ({hi, lo} !== e || e !== 64'hFFFFFFFF_FFFFFFFE) begin n_bad++; $display("FAIL mult got %h want %h", {hi, lo}, e); end
      issue(MD_MULTU, 32'hFFFFFFFF, 32'h2);
      drain(n);
      e = q.pop_front();
      n_cmp++;
      if ({hi, lo} !== e || e !== 64'h00000001_FFFFFFFE) begin n_bad++; $display("FAIL multu got %h want %h", {hi, lo}, e); end
   endtask
   task automatic test_div;
      int n;
      logic [63:0] e;
      issue(MD_DIVU, 32'd7, 32'd2);
      drain(n);
      e = q.pop_front();
      n_cmp++;
      if (n !== 10) begin n_bad++; $display("FAIL divu_lat got %0d want 10", n); end
      n_cmp++;
      if ({hi, lo} !== e || e !== 64'h1_00000003) begin n_bad++; $display("FAIL divu got %h want %h", {hi, lo}, e); end
      issue(MD_DIV, 32'hFFFFFFF9, 32'd2);
      drain(n);
      e = q.pop_front();
      n_cmp++;
      if ({hi, lo} !== e || e !== 64'hFFFFFFFF_FFFFFFFD) begin n_bad++; $display("FAIL div got %h want %h", {hi, lo}, e); end
   endtask
   task automatic test_stall;
      int n;
      logic [63:0] e;
      md_in_d = 1'b1;
      op_e = MD_MULT;
      src_a = 32'd3;
      src_b = 32'hFFFFFFFC;
      e = model(MD_MULT, src_a, src_b, {m_hi, m_lo});
      {m_hi, m_lo} = e;
      q.push_back(e);
      n = 0;
      #1;
      while (stall_req && n < 40) begin
         n++;
         @(negedge clk);
         op_e = MD_NONE;
      end
      n_cmp++;
      if (n !== 6) begin n_bad++; $display("FAIL stall_len got %0d want 6", n); end
      n_cmp++;
      if (busy !== 1'b0) begin n_bad++; $display("FAIL stall_busy got %b want 0", busy); end
      e = q.pop_front();
      md_in_d = 1'b0;
      op_e = MD_MFHI;
      #1;
      n_cmp++;
      if (result_e !== e[63:32]) begin n_bad++; $display("FAIL mfhi got %h want %h", result_e, e[63:32]); end
      op_e = MD_MFLO;
      #1;
      n_cmp++;
      if (result_e !== e[31:0]) begin n_bad++; $display("FAIL mflo got %h want %h", result_e, e[31:0]); end
      @(negedge clk);
      op_e = MD_NONE;
   endtask
   task automatic test_div_zero;
      int n;
      logic [63:0] e;
      issue(MD_MTLO, 32'h12345678, 32'd0);
      e = q.pop_front();
      n_cmp++;
      if (busy !== 1'b0 || lo !== 32'h12345678 || {hi, lo} !== e) begin n_bad++; $display("FAIL mtlo got %b/%h want 0/%h", busy, {hi, lo}, e); end
      issue(MD_DIV, 32'd5, 32'd0);
      drain(n);
      e = q.pop_front();
      n_cmp++;
      if (n !== 10) begin n_bad++; $display("FAIL divz_lat got %0d want 10", n); end
      n_cmp++;
      if ({hi, lo} !== e || lo !== 32'h12345678) begin n_bad++; $display("FAIL divz got %h want %h", {hi, lo}, e); end
   endtask
   task automatic test_reset_mid;
      issue(MD_MULT, 32'd1234, 32'd5678);
      void'(q.pop_back());
      repeat (2) @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      m_hi = '0;
      m_lo = '0;
      n_cmp++;
      if ({busy, hi, lo} !== 65'd0) begin n_bad++; $display("FAIL rst_mid got %h want 0", {busy, hi, lo}); end
      repeat (6) @(negedge clk);
      op_e = MD_MFLO;
      #1;
      n_cmp++;
      if ({result_e, hi} !== 64'd0) begin n_bad++; $display("FAIL rst_mflo got %h want 0", {result_e, hi}); end
      @(negedge clk);
      op_e = MD_NONE;
   endtask
   task automatic test_madd;
      int n;
      logic [63:0] e;
      issue(MD_MTLO, 32'hFFFFFFFF, 32'd0);
      issue(MD_MTHI, 32'd0, 32'd0);
      q.delete();
      issue(MD_MADDU, 32'd1, 32'd1);
      drain(n);
      e = q.pop_front();
      n_cmp++;
      if (n !== lat(MD_MADDU)) begin n_bad++; $display("FAIL maddu_lat got %0d want %0d", n, lat(MD_MADDU)); end
`ifdef MDU_MADD_EN
      n_cmp++;
      if ({hi, lo} !== e || e !== 64'h1_00000000) begin n_bad++; $display("FAIL maddu got %h want %h", {hi, lo}, e); end
`else
      n_cmp++;
      if ({hi, lo} !== e || e !== 64'h0_FFFFFFFF) begin n_bad++; $display("FAIL maddu got %h want %h", {hi, lo}, e); end
`endif
   endtask
   task automatic test_back_to_back;
      int n;
      logic [63:0] e;
      logic [3:0] ops [8] = '{MD_MULT, MD_MULTU, MD_DIV, MD_DIVU, MD_MTHI, MD_MTLO, MD_MSUB, MD_MADD};
      logic [3:0] op;
      logic [31:0] a, b;
      for (int i = 0; i < 24; i++) begin
         op = ops[$urandom_range(0, 7)];
         a = $urandom();
         b = (i % 5 == 0) ? 32'd0 : $urandom();
         if (b[31] && op == MD_DIV) b = b >> $urandom_range(0, 31);
         issue(op, a, b);
         drain(n);
         e = q.pop_front();
         n_cmp++;
         if (n !== lat(op)) begin n_bad++; $display("FAIL b2b_lat op %0d got %0d want %0d", op, n, lat(op)); end
         n_cmp++;
         if ({hi, lo} !== e) begin n_bad++; $display("FAIL b2b op %0d a %h b %h got %h want %h", op, a, b, {hi, lo}, e); end
      end
   endtask
   initial begin
      @(negedge clk);
      test_reset;
      test_mult;
      test_div;
      test_stall;
      test_div_zero;
      test_reset_mid;
      test_madd;
      test_back_to_back;
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
